pipe_sel_mux: RTL and testbench
===============================

Name: pipe_sel_mux

Overview:
- Parametrised, registered N:1 data selector with valid/ready handshake. Successor to the combinational 8-bit 2:1 mux used on the datapath.
- Sits between pipeline stages and selects one of NUM_IN operand/forwarding sources.
- Adds one register stage, a 2-entry skid buffer so in_ready is driven from a flop, flush support, and out-of-range select detection.

Parameters:
- WIDTH, 8, data width of each input and of the output.
- NUM_IN, 4, number of selectable inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  index of the input to capture.
- in_valid  in  1  upstream presents in_data/in_sel.
- in_ready  out  1  block can accept this cycle; registered output.
- flush  in  1  synchronous discard of all held entries.
- out_data  out  WIDTH  selected, registered data.
- out_sel  out  SEL_W  select value that produced out_data.
- sel_err  out  1  out_data came from an out-of-range select (in_sel >= NUM_IN).
- out_valid  out  1  out_data/out_sel/sel_err are valid.
- out_ready  in  1  downstream accepts this cycle.

Behaviour:
- Reset (sync, priority over everything): out_valid=0, out_data=0, out_sel=0, sel_err=0, in_ready=1, skid entry cleared.
- Accept occurs when in_valid && in_ready. Capture occurs when out_valid && out_ready.
- Selection: captured word = input[in_sel] sampled in the accept cycle.
  - If in_sel >= NUM_IN, captured word = input 0 and sel_err=1 for that entry.
  - sel_err, out_sel and out_data always travel together as one entry.
- Latency: an accept in cycle T makes the entry visible on out_* in cycle T+1 if the output register is free or drains that cycle.
- Storage states:
  - EMPTY: out_valid=0, skid empty.
  - ONE: out_valid=1, skid empty.
  - FULL: out_valid=1, skid holds one entry.
  - in_ready = (state != FULL), registered.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + capture -> ONE; the new entry replaces the output register.
  - ONE + accept, no capture -> FULL; the new entry goes to skid.
  - ONE + capture, no accept -> EMPTY.
  - FULL + capture -> ONE; skid moves to the output register. No accept is possible in FULL since in_ready=0.
  - All other cases hold state.
- Stability: while out_valid=1 and out_ready=0, out_data/out_sel/sel_err hold constant.
- Ordering: strict FIFO; entries leave in accept order; none dropped or duplicated except on flush.
- Flush:
  - Next cycle: out_valid=0, skid cleared, in_ready=1, state EMPTY.
  - out_data/out_sel/sel_err keep their last values, which are don't-care while out_valid=0.
  - An accept coincident with flush is discarded.
  - A capture coincident with flush counts as completed downstream.
- in_valid may drop without a transfer; no upstream stability requirement beyond the accept cycle.
- Must sustain one transfer per cycle with out_ready held high.
- No combinational path from out_ready to in_ready.

Test Plan:
- Reset then streaming: WIDTH=8, NUM_IN=4, inputs 0x11/0x22/0x33/0x44, out_ready=1, in_sel=2,0,3 on consecutive cycles -> out_data 0x33, 0x11, 0x44 on cycles T+1..T+3. out_valid stays 1, in_ready stays 1, sel_err=0.
- Backpressure: out_ready=0, push sel=1 then sel=3 -> out_data=0x22 held stable, in_ready=0 after the second accept. A third in_valid is not accepted. Raise out_ready -> 0x22 then 0x44, in_ready returns to 1.
- Out-of-range: NUM_IN=3, SEL_W=2, in_sel=3, in_data[0]=0xA5 -> out_data=0xA5, out_sel=3, sel_err=1 next cycle. Next entry with sel=1 has sel_err=0.
- Flush in FULL: fill both entries, then assert flush together with in_valid -> next cycle out_valid=0, in_ready=1. The flushed-cycle input never appears on the output.
- Reset mid-operation: reset asserted while FULL and out_ready=0 -> next cycle out_valid=0, out_data=0, out_sel=0, sel_err=0, in_ready=1. First accept after reset appears one cycle later.
- Random soak: random in_valid/out_ready/in_sel for 10k cycles -> scoreboard confirms FIFO order, no loss or duplication, and stability under stall.

Source files
------------

// File: rtl/pipe_sel_mux.sv
// pipe_sel_mux: registered NUM_IN:1 data selector with a valid/ready handshake,
// a 2-entry store (output register + skid entry), flush, and out-of-range select
// detection.
//
// Ports:
//   clk_i        rising-edge clock for all state
//   reset_i      synchronous active-high reset, highest priority
//   in_data_i    flattened inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel_i     index of the input to capture on accept
//   in_valid_i   upstream offers in_data_i/in_sel_i
//   in_ready_o   block can accept this cycle (driven straight from a flop)
//   flush_i      discard every held entry; coincident accept is dropped
//   out_data_o   selected data of the head entry
//   out_sel_o    select value that produced out_data_o
//   sel_err_o    head entry came from an out-of-range select
//   out_valid_o  out_data_o/out_sel_o/sel_err_o are valid
//   out_ready_i  downstream takes the head entry this cycle
//
// Latency: an accept in cycle T is visible on out_* in cycle T+1 when the
// output register is free or drains in cycle T. One transfer per cycle is
// sustained while out_ready_i stays high.
// Backpressure: in_ready_o depends only on registered state, so there is no
// combinational path from out_ready_i to in_ready_o. The skid entry absorbs the
// one word that can arrive in the cycle the output stalls.

module pipe_sel_mux #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_IN*WIDTH-1:0] in_data_i,
  input  logic [SEL_W-1:0]        in_sel_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    flush_i,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [SEL_W-1:0]        out_sel_o,
  output logic                    sel_err_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i
);

  // Storage occupancy: EMPTY = nothing held, ONE = output register only,
  // FULL = output register plus skid entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_q;

  logic [WIDTH-1:0]   out_data_q;
  logic [SEL_W-1:0]   out_sel_q;
  logic               sel_err_q;
  logic               out_valid_q;
  logic               in_ready_q;

  logic [WIDTH-1:0]   skid_data_q;
  logic [SEL_W-1:0]   skid_sel_q;
  logic               skid_err_q;

  // Entry formed from the current inputs; it is only stored on an accept.
  logic [WIDTH-1:0]   new_data_d;
  logic               new_err_d;

  logic               accept;
  logic               capture;

  assign accept  = in_valid_i && in_ready_q;
  assign capture = out_valid_q && out_ready_i;

  // Input selection. Any select that matches no implemented input falls back
  // to input 0 and flags the entry, so an illegal index never reads outside
  // the flattened bus.
  always_comb begin
    new_data_d = in_data_i[WIDTH-1:0];
    new_err_d  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(in_sel_i) == k) begin
        new_data_d = in_data_i[k*WIDTH +: WIDTH];
        new_err_d  = 1'b0;
      end
    end
  end

  // Occupancy FSM together with all of the datapath registers it steers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      sel_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_err_q  <= 1'b0;
    end else if (flush_i) begin
      // The output word is left as-is; it is meaningless while out_valid is
      // low. A capture in this cycle already completed downstream, and an
      // accept in this cycle is dropped.
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_data_q  <= new_data_d;
            out_sel_q   <= in_sel_i;
            sel_err_q   <= new_err_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end

        ST_ONE: begin
          if (accept && capture) begin
            // Head leaves as the new entry arrives: replace in place.
            out_data_q <= new_data_d;
            out_sel_q  <= in_sel_i;
            sel_err_q  <= new_err_d;
          end else if (accept) begin
            // Output is stalled: park the new entry and stop accepting.
            skid_data_q <= new_data_d;
            skid_sel_q  <= in_sel_i;
            skid_err_q  <= new_err_d;
            in_ready_q  <= 1'b0;
            state_q     <= ST_FULL;
          end else if (capture) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end

        ST_FULL: begin
          // in_ready is low here, so only a capture can change anything.
          if (capture) begin
            out_data_q <= skid_data_q;
            out_sel_q  <= skid_sel_q;
            sel_err_q  <= skid_err_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end

        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;
  assign sel_err_o   = sel_err_q;
  assign out_valid_o = out_valid_q;
  assign in_ready_o  = in_ready_q;

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Bench for pipe_sel_mux: two instances (NUM_IN=4 and NUM_IN=3) share one
// stimulus stream; each has its own expected-entry queue that is filled on
// accepts and drained by a monitor on captures.

module tb_pipe_sel_mux;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] s;
    logic       e;
  } ent_t;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        flush;
  logic        out_ready;

  logic       rdy4, vld4, err4;
  logic [7:0] dat4;
  logic [1:0] sel4;
  logic       rdy3, vld3, err3;
  logic [7:0] dat3;
  logic [1:0] sel3;

  int checks   = 0;
  int failures = 0;

  ent_t q4[$];
  ent_t q3[$];
  bit   post_rst = 1'b0;

  pipe_sel_mux #(.WIDTH(8), .NUM_IN(4), .SEL_W(2)) u_dut4 (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_data_i   (in_data),
    .in_sel_i    (in_sel),
    .in_valid_i  (in_valid),
    .in_ready_o  (rdy4),
    .flush_i     (flush),
    .out_data_o  (dat4),
    .out_sel_o   (sel4),
    .sel_err_o   (err4),
    .out_valid_o (vld4),
    .out_ready_i (out_ready)
  );

  pipe_sel_mux #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) u_dut3 (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_data_i   (in_data[23:0]),
    .in_sel_i    (in_sel),
    .in_valid_i  (in_valid),
    .in_ready_o  (rdy3),
    .flush_i     (flush),
    .out_data_o  (dat3),
    .out_sel_o   (sel3),
    .sel_err_o   (err3),
    .out_valid_o (vld3),
    .out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference selection: the entry a selector with n inputs must produce.
  function automatic ent_t ref_entry(input int n, input logic [1:0] sel,
                                     input logic [31:0] words);
    ent_t r;
    r.s = sel;
    if (int'(sel) >= n) begin
      r.d = words[7:0];
      r.e = 1'b1;
    end else begin
      r.d = words[int'(sel)*8 +: 8];
      r.e = 1'b0;
    end
    return r;
  endfunction

  // Compare one instance's visible state against its expected queue.
  task automatic check_dut(input string nm, input int qsize, input ent_t head,
                           input logic rdy, input logic vld, input logic [7:0] d,
                           input logic [1:0] s, input logic e);
    chk({nm, ".in_ready"}, 32'(rdy), 32'(qsize < 2));
    chk({nm, ".out_valid"}, 32'(vld), 32'(qsize > 0));
    if (qsize > 0) begin
      chk({nm, ".out_data"}, 32'(d), 32'(head.d));
      chk({nm, ".out_sel"}, 32'(s), 32'(head.s));
      chk({nm, ".sel_err"}, 32'(e), 32'(head.e));
    end
  endtask

  // Monitor: inputs are stable at the falling edge, so the DUT outputs are
  // checked here and the queues are advanced to what the next rising edge
  // must produce.
  always @(negedge clk) begin
    ent_t h4, h3;
    bit   cap, acc4, acc3;
    if (reset) begin
      q4.delete();
      q3.delete();
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        chk("rst4.out_data", 32'(dat4), 32'h0);
        chk("rst4.out_sel", 32'(sel4), 32'h0);
        chk("rst4.sel_err", 32'(err4), 32'h0);
        chk("rst3.out_data", 32'(dat3), 32'h0);
        chk("rst3.sel_err", 32'(err3), 32'h0);
        post_rst = 1'b0;
      end
      h4 = (q4.size() > 0) ? q4[0] : '0;
      h3 = (q3.size() > 0) ? q3[0] : '0;
      check_dut("n4", q4.size(), h4, rdy4, vld4, dat4, sel4, err4);
      check_dut("n3", q3.size(), h3, rdy3, vld3, dat3, sel3, err3);

      cap  = out_ready;
      acc4 = in_valid && (q4.size() < 2);
      acc3 = in_valid && (q3.size() < 2);
      if (flush) begin
        q4.delete();
        q3.delete();
      end else begin
        if (cap && q4.size() > 0) void'(q4.pop_front());
        if (cap && q3.size() > 0) void'(q3.pop_front());
        if (acc4) q4.push_back(ref_entry(4, in_sel, in_data));
        if (acc3) q3.push_back(ref_entry(3, in_sel, in_data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic ordy,
                       input logic fl);
    in_valid  = v;
    in_sel    = s;
    out_ready = ordy;
    flush     = fl;
    step();
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = 32'h44332211;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Streaming at full rate.
    drive(1'b1, 2'd2, 1'b1, 1'b0);
    drive(1'b1, 2'd0, 1'b1, 1'b0);
    drive(1'b1, 2'd3, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);

    // Backpressure: fill, offer a third word, then drain.
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);

    // Out-of-range select with a distinctive input 0.
    in_data = 32'h443322A5;
    drive(1'b1, 2'd3, 1'b1, 1'b0);
    drive(1'b1, 2'd1, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);

    // Flush while full, with a coincident offered word.
    in_data = 32'h44332211;
    drive(1'b1, 2'd0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 1'b1);
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);

    // Reset while full and stalled, then a fresh accept.
    drive(1'b1, 2'd3, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 2'd2, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);

    // Random soak.
    for (int i = 0; i < 10000; i++) begin
      in_data   = $urandom;
      in_sel    = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 63) == 0);
      reset     = ($urandom_range(0, 255) == 0);
      step();
    end

    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
